// File: rtl/cnn_sched.sv
// Round-robin frame scheduler that time-shares one 3-tap smoothing filter among four sources.
// Each frame is preceded by zero samples that flush the filter history; results return tagged.
module cnn_sched #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned FLUSH_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  s_valid,
    input  logic [31:0] s_data,
    output logic [3:0]  s_ready,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [7:0]  f_in,
    output logic        f_i_en,
    input  logic [7:0]  f_out,
    output logic [7:0]  m_data,
    output logic [1:0]  m_ch,
    output logic        m_valid
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

    state_t        state;
    logic [1:0]    phase;
    logic [1:0]    owner;
    logic [1:0]    last;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] issue_cnt;
    logic          pending;
    logic          ending;

    logic [7:0]    owner_data;
    logic          slot;
    logic          flush_issue;
    logic          run_issue;
    logic          req_drop;

    // First requester found scanning upward from last+1, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] c;
        rr_pick = l;
        for (int k = 4; k >= 1; k--) begin
            c = l + 2'(k);
            if (r[c]) rr_pick = c;
        end
    endfunction

    assign busy = (state != IDLE);

    // Issue decisions happen only in the phase-0 slot of the 3-cycle cadence.
    always_comb begin
        owner_data  = s_data[{owner, 3'b000} +: 8];
        slot        = busy && (phase == 2'd0);
        flush_issue = (state == FLUSH) && (phase == 2'd0) && (flush_cnt < CW'(FLUSH_LEN));
        req_drop    = (state == RUN) && (phase == 2'd0) && !ending && !req[owner];
        run_issue   = (state == RUN) && (phase == 2'd0) && !ending && req[owner] && s_valid[owner];
        f_i_en      = flush_issue || run_issue;
        f_in        = run_issue ? owner_data : 8'd0;
        s_ready     = run_issue ? (4'b0001 << owner) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 2'd0;
            owner     <= 2'd0;
            last      <= 2'd3;
            grant     <= 4'b0000;
            flush_cnt <= '0;
            issue_cnt <= '0;
            pending   <= 1'b0;
            ending    <= 1'b0;
            m_data    <= 8'd0;
            m_ch      <= 2'd0;
            m_valid   <= 1'b0;
        end else begin
            m_valid <= 1'b0;

            // A RUN issue at one slot edge is captured at the next slot edge, three cycles later.
            if (slot) begin
                if (pending) begin
                    m_data  <= f_out;
                    m_ch    <= owner;
                    m_valid <= 1'b1;
                end
                pending <= run_issue;
            end

            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= rr_pick(req, last);
                        last      <= rr_pick(req, last);
                        grant     <= 4'b0001 << rr_pick(req, last);
                        flush_cnt <= '0;
                        issue_cnt <= '0;
                        ending    <= 1'b0;
                        phase     <= 2'd0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    if (flush_issue) flush_cnt <= flush_cnt + CW'(1);
                    if ((phase == 2'd2) && (flush_cnt == CW'(FLUSH_LEN))) state <= RUN;
                end
                RUN: begin
                    phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    if (run_issue) begin
                        issue_cnt <= issue_cnt + CW'(1);
                        if (issue_cnt + CW'(1) == CW'(FRAME_LEN)) ending <= 1'b1;
                    end
                    // Frame closes on the edge that captures the last pending result.
                    if (req_drop || (ending && slot)) begin
                        state  <= IDLE;
                        grant  <= 4'b0000;
                        phase  <= 2'd0;
                        ending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
